// File: rtl/i2c_target_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_target_if                                                        |
// | Pad and host-register signals of the I2C target.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface i2c_target_if;
  logic       scl_i;
  logic       scl_o;
  logic       scl_t;
  logic       sda_i;
  logic       sda_o;
  logic       sda_t;
  logic       wr_val_o;
  logic [7:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic [7:0] rd_addr_o;
  logic [7:0] rd_data_i;
  logic       rd_stb_o;
  logic       busy_o;

  modport slave (
    input  scl_i, sda_i, rd_data_i,
    output scl_o, scl_t, sda_o, sda_t, wr_val_o, wr_addr_o, wr_data_o,
           rd_addr_o, rd_stb_o, busy_o
  );

  modport master (
    output scl_i, sda_i, rd_data_i,
    input  scl_o, scl_t, sda_o, sda_t, wr_val_o, wr_addr_o, wr_data_o,
           rd_addr_o, rd_stb_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_target                                                           |
// | Oversampled I2C target with 8-bit register pointer and strobes.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module i2c_target #(
  parameter logic [6:0] DADDR = 7'h50,
  parameter int         SYNC  = 2
) (
  input  wire logic  clk_i,
  input  wire logic  rst_ni,
  input  wire logic  srst_i,
  i2c_target_if.slave bus
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_DADR   = 4'd1,
    ST_DACK   = 4'd2,
    ST_REGA   = 4'd3,
    ST_RACK   = 4'd4,
    ST_WDAT   = 4'd5,
    ST_WACK   = 4'd6,
    ST_RDAT   = 4'd7,
    ST_MACK   = 4'd8,
    ST_IGNORE = 4'd9
  } state_t;

  logic [SYNC-1:0] r_scl_sync, r_sda_sync;
  logic            r_scl_d, r_sda_d;
  state_t          r_state, w_state_n;
  logic [7:0]      r_shift, w_shift_n;
  logic [2:0]      r_cnt, w_cnt_n;
  logic [7:0]      r_ptr, w_ptr_n;
  logic            r_rw, w_rw_n;
  logic            r_acked, w_acked_n;
  logic            r_sda_t, w_sda_t_n;
  logic            r_wr_val, w_wr_val_n;
  logic [7:0]      r_wr_addr, w_wr_addr_n;
  logic [7:0]      r_wr_data, w_wr_data_n;
  logic            r_rd_stb, w_rd_stb_n;
  logic            r_busy, w_busy_n;

  logic       w_scl, w_sda, w_rise, w_fall, w_start, w_stop;
  logic [7:0] w_byte;

  assign w_scl   = r_scl_sync[SYNC-1];
  assign w_sda   = r_sda_sync[SYNC-1];
  assign w_rise  = w_scl & ~r_scl_d;
  assign w_fall  = ~w_scl & r_scl_d;
  assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte  = {r_shift[6:0], w_sda};

  always_comb begin
    w_state_n   = r_state;
    w_shift_n   = r_shift;
    w_cnt_n     = r_cnt;
    w_ptr_n     = r_ptr;
    w_rw_n      = r_rw;
    w_acked_n   = r_acked;
    w_sda_t_n   = r_sda_t;
    w_wr_val_n  = 1'b0;
    w_wr_addr_n = r_wr_addr;
    w_wr_data_n = r_wr_data;
    w_rd_stb_n  = 1'b0;
    w_busy_n    = r_busy;
    if (w_stop) begin
      w_state_n = ST_IDLE;
      w_sda_t_n = 1'b0;
      w_busy_n  = 1'b0;
    end else if (w_start) begin
      w_state_n = ST_DADR;
      w_sda_t_n = 1'b0;
      w_cnt_n   = 3'd0;
      w_acked_n = 1'b0;
    end else begin
      case (r_state)
        ST_DADR, ST_REGA, ST_WDAT: begin
          if (w_rise) begin
            w_shift_n = w_byte;
            w_cnt_n   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              if (r_state == ST_DADR) begin
                // General call is never acknowledged, even if DADDR is 0.
                if (w_byte[7:1] == DADDR && w_byte[7:1] != 7'd0) begin
                  w_state_n = ST_DACK;
                  w_rw_n    = w_byte[0];
                end else begin
                  w_state_n = ST_IGNORE;
                end
              end else if (r_state == ST_REGA) begin
                w_ptr_n   = w_byte;
                w_state_n = ST_RACK;
              end else begin
                w_wr_val_n  = 1'b1;
                w_wr_addr_n = r_ptr;
                w_wr_data_n = w_byte;
                w_ptr_n     = r_ptr + 8'd1;
                w_state_n   = ST_WACK;
              end
            end
          end
        end
        ST_DACK, ST_RACK, ST_WACK: begin
          // First fall asserts ACK, second fall ends it.
          if (w_fall) begin
            if (!r_sda_t) begin
              w_sda_t_n = 1'b1;
              if (r_state == ST_DACK) w_busy_n = 1'b1;
            end else if (r_state == ST_DACK && r_rw) begin
              w_shift_n  = {bus.rd_data_i[6:0], 1'b0};
              w_sda_t_n  = ~bus.rd_data_i[7];
              w_rd_stb_n = 1'b1;
              w_cnt_n    = 3'd1;
              w_state_n  = ST_RDAT;
            end else begin
              w_sda_t_n = 1'b0;
              w_cnt_n   = 3'd0;
              w_state_n = (r_state == ST_DACK) ? ST_REGA : ST_WDAT;
            end
          end
        end
        ST_RDAT: begin
          if (w_fall) begin
            if (r_cnt == 3'd0) begin
              w_sda_t_n = 1'b0;
              w_acked_n = 1'b0;
              w_state_n = ST_MACK;
            end else begin
              w_sda_t_n = ~r_shift[7];
              w_shift_n = {r_shift[6:0], 1'b0};
              w_cnt_n   = r_cnt + 3'd1;
            end
          end
        end
        ST_MACK: begin
          if (w_rise) begin
            if (!w_sda) begin
              w_ptr_n   = r_ptr + 8'd1;
              w_acked_n = 1'b1;
            end else begin
              w_state_n = ST_IGNORE;
            end
          end else if (w_fall && r_acked) begin
            w_shift_n  = {bus.rd_data_i[6:0], 1'b0};
            w_sda_t_n  = ~bus.rd_data_i[7];
            w_rd_stb_n = 1'b1;
            w_cnt_n    = 3'd1;
            w_acked_n  = 1'b0;
            w_state_n  = ST_RDAT;
          end
        end
        default: w_sda_t_n = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_state    <= ST_IDLE;
      r_shift    <= 8'd0;
      r_cnt      <= 3'd0;
      r_ptr      <= 8'd0;
      r_rw       <= 1'b0;
      r_acked    <= 1'b0;
      r_sda_t    <= 1'b0;
      r_wr_val   <= 1'b0;
      r_wr_addr  <= 8'd0;
      r_wr_data  <= 8'd0;
      r_rd_stb   <= 1'b0;
      r_busy     <= 1'b0;
    end else if (srst_i) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_state    <= ST_IDLE;
      r_shift    <= 8'd0;
      r_cnt      <= 3'd0;
      r_ptr      <= 8'd0;
      r_rw       <= 1'b0;
      r_acked    <= 1'b0;
      r_sda_t    <= 1'b0;
      r_wr_val   <= 1'b0;
      r_wr_addr  <= 8'd0;
      r_wr_data  <= 8'd0;
      r_rd_stb   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC-2:0], bus.scl_i};
      r_sda_sync <= {r_sda_sync[SYNC-2:0], bus.sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      r_state    <= w_state_n;
      r_shift    <= w_shift_n;
      r_cnt      <= w_cnt_n;
      r_ptr      <= w_ptr_n;
      r_rw       <= w_rw_n;
      r_acked    <= w_acked_n;
      r_sda_t    <= w_sda_t_n;
      r_wr_val   <= w_wr_val_n;
      r_wr_addr  <= w_wr_addr_n;
      r_wr_data  <= w_wr_data_n;
      r_rd_stb   <= w_rd_stb_n;
      r_busy     <= w_busy_n;
    end
  end

  assign bus.scl_o     = 1'b0;
  assign bus.scl_t     = 1'b0;
  assign bus.sda_o     = 1'b0;
  assign bus.sda_t     = r_sda_t;
  assign bus.wr_val_o  = r_wr_val;
  assign bus.wr_addr_o = r_wr_addr;
  assign bus.wr_data_o = r_wr_data;
  assign bus.rd_addr_o = r_ptr;
  assign bus.rd_stb_o  = r_rd_stb;
  assign bus.busy_o    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_i2c_target                                                        |
// | Bus-level bench: I2C master tasks, register model, strobe monitor.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_i2c_target;
  localparam int Q = 5;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic srst_i = 1'b0;
  logic m_sda  = 1'b1;
  logic [7:0] mem [256];

  i2c_target_if bus();
  i2c_target #(.DADDR(7'h50), .SYNC(2)) dut (
    .clk_i (clk_i), .rst_ni(rst_ni), .srst_i(srst_i), .bus(bus.slave)
  );

  always #5 clk_i = ~clk_i;
  assign bus.sda_i     = m_sda & ~bus.sda_t;
  assign bus.rd_data_i = mem[bus.rd_addr_o];

  int n_checks = 0;
  int n_pass   = 0;
  int wr_n = 0, stb_n = 0, sdat_n = 0, busy_n = 0, hi_chg = 0;
  logic [15:0] wr_log [1024];
  logic prev_sdat = 1'b0;
  logic mon_en = 1'b1;

  always @(negedge clk_i) begin
    if (bus.wr_val_o) begin
      wr_log[wr_n[9:0]] <= {bus.wr_addr_o, bus.wr_data_o};
      wr_n <= wr_n + 1;
    end
    if (bus.rd_stb_o) stb_n <= stb_n + 1;
    if (bus.sda_t) sdat_n <= sdat_n + 1;
    if (bus.busy_o) busy_n <= busy_n + 1;
    if (mon_en && rst_ni && bus.scl_i && (bus.sda_t != prev_sdat)) hi_chg <= hi_chg + 1;
    prev_sdat <= bus.sda_t;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic m_start();
    m_sda = 1'b1; tick(Q); bus.scl_i = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q); bus.scl_i = 1'b0; tick(Q);
  endtask

  task automatic m_stop();
    m_sda = 1'b0; tick(Q); bus.scl_i = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
  endtask

  task automatic m_bit(input logic b, output logic line);
    m_sda = b; tick(Q); bus.scl_i = 1'b1; tick(Q);
    line = bus.sda_i; tick(Q); bus.scl_i = 1'b0; tick(Q);
  endtask

  task automatic m_wbyte(input logic [7:0] d, output logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) m_bit(d[i], l);
    m_bit(1'b1, l);
    ack = ~l;
  endtask

  task automatic m_rbyte(input logic mack, output logic [7:0] d);
    logic l;
    for (int i = 7; i >= 0; i--) begin m_bit(1'b1, l); d[i] = l; end
    m_bit(~mack, l);
  endtask

  task automatic do_write(input logic [7:0] dbyte, input logic [7:0] rega, input int n,
                          input logic [23:0] d, output int acks);
    logic a;
    acks = 0;
    m_start();
    m_wbyte(dbyte, a); acks += int'(a);
    m_wbyte(rega, a);  acks += int'(a);
    for (int i = 0; i < n; i++) begin m_wbyte(d[8*i +: 8], a); acks += int'(a); end
    m_stop();
  endtask

  task automatic do_read(input logic [7:0] rega, input int n, output logic [23:0] d, output int acks);
    logic a;
    logic [7:0] b;
    acks = 0;
    d = '0;
    m_start();
    m_wbyte(8'hA0, a); acks += int'(a);
    m_wbyte(rega, a);  acks += int'(a);
    m_start();
    m_wbyte(8'hA1, a); acks += int'(a);
    for (int i = 0; i < n; i++) begin m_rbyte(i != n - 1, b); d[8*i +: 8] = b; end
    m_stop();
  endtask

  typedef struct {
    logic [7:0]  dbyte;
    logic [7:0]  rega;
    int          n;
    logic [23:0] d;
    int          exp_acks;
    int          exp_wr;
    logic [7:0]  exp_ptr;
  } vec_t;

  vec_t vt [5];
  int acks, b_wr, b_stb, b_sdat, b_busy, n, kind, got;
  logic [7:0] ptr_m, rega, dbyte, ea;
  logic [23:0] dd, rd;
  logic hit;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{8'hA0, 8'h12, 1, 24'h00005A, 3, 1, 8'h13};
    vt[1] = '{8'hA0, 8'hFF, 2, 24'h000201, 4, 2, 8'h01};
    vt[2] = '{8'hA2, 8'h33, 1, 24'h000077, 0, 0, 8'h01};
    vt[3] = '{8'h00, 8'h44, 1, 24'h000011, 0, 0, 8'h01};
    vt[4] = '{8'hA0, 8'h80, 3, 24'h332211, 5, 3, 8'h83};
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    bus.scl_i = 1'b1;

    tick(3);
    chk("rst_sda_t",   32'(bus.sda_t), 0);
    chk("rst_wr_val",  32'(bus.wr_val_o), 0);
    chk("rst_rd_stb",  32'(bus.rd_stb_o), 0);
    chk("rst_wr_addr", 32'(bus.wr_addr_o), 0);
    chk("rst_wr_data", 32'(bus.wr_data_o), 0);
    chk("rst_busy",    32'(bus.busy_o), 0);
    chk("rst_ptr",     32'(bus.rd_addr_o), 0);
    chk("scl_t_tied",  32'(bus.scl_t), 0);
    rst_ni = 1'b1;
    tick(4);

    for (int v = 0; v < 5; v++) begin
      b_wr = wr_n; b_sdat = sdat_n; b_busy = busy_n;
      do_write(vt[v].dbyte, vt[v].rega, vt[v].n, vt[v].d, acks);
      tick(2);
      chk("vec_acks", 32'(acks), 32'(vt[v].exp_acks));
      chk("vec_wr_count", 32'(wr_n - b_wr), 32'(vt[v].exp_wr));
      for (int i = 0; i < vt[v].exp_wr && i < wr_n - b_wr; i++) begin
        ea = vt[v].rega + 8'(i);
        chk("vec_wr_addr", 32'(wr_log[b_wr + i][15:8]), 32'(ea));
        chk("vec_wr_data", 32'(wr_log[b_wr + i][7:0]), 32'(vt[v].d[8*i +: 8]));
      end
      chk("vec_ptr", 32'(bus.rd_addr_o), 32'(vt[v].exp_ptr));
      chk("vec_sda_driven", 32'(sdat_n != b_sdat), 32'(vt[v].exp_acks != 0));
      chk("vec_busy_seen", 32'(busy_n != b_busy), 32'(vt[v].exp_acks != 0));
      chk("vec_busy_after_stop", 32'(bus.busy_o), 0);
    end

    // Read with master ACK then NACK
    mem[8'h40] = 8'hC3; mem[8'h41] = 8'h3C;
    b_stb = stb_n; b_wr = wr_n;
    do_read(8'h40, 2, rd, acks);
    tick(2);
    chk("rd_acks", 32'(acks), 3);
    chk("rd_byte0", 32'(rd[7:0]), 32'h C3);
    chk("rd_byte1", 32'(rd[15:8]), 32'h3C);
    chk("rd_stb_count", 32'(stb_n - b_stb), 2);
    chk("rd_no_write", 32'(wr_n - b_wr), 0);
    chk("rd_ptr", 32'(bus.rd_addr_o), 32'h41);
    chk("rd_sda_released", 32'(bus.sda_t), 0);

    // STOP after four data bits aborts the byte
    b_wr = wr_n;
    begin
      logic a, l;
      m_start(); m_wbyte(8'hA0, a); m_wbyte(8'h20, a);
      for (int i = 0; i < 4; i++) m_bit(1'b1, l);
      m_stop();
    end
    tick(2);
    chk("abort_no_wr", 32'(wr_n - b_wr), 0);
    chk("abort_busy", 32'(bus.busy_o), 0);
    chk("abort_ptr", 32'(bus.rd_addr_o), 32'h20);
    b_wr = wr_n;
    do_write(8'hA0, 8'h21, 1, 24'h000099, acks);
    tick(2);
    chk("post_abort_acks", 32'(acks), 3);
    chk("post_abort_wr_count", 32'(wr_n - b_wr), 1);
    chk("post_abort_wr", 32'(wr_log[b_wr]), 32'h2199);

    // Randomized traffic against a pointer/memory model
    ptr_m = bus.rd_addr_o;
    for (int t = 0; t < 12; t++) begin
      kind = int'($urandom_range(0, 2));
      n    = int'($urandom_range(1, 3));
      rega = 8'($urandom);
      dd   = 24'($urandom);
      b_wr = wr_n; b_stb = stb_n;
      if (kind < 2) begin
        dbyte = ($urandom_range(0, 1) == 0) ? 8'hA0 : {7'($urandom), 1'b0};
        hit = (dbyte[7:1] == 7'h50);
        do_write(dbyte, rega, n, dd, acks);
        tick(2);
        chk("rnd_w_acks", 32'(acks), hit ? 32'(n + 2) : 0);
        chk("rnd_w_count", 32'(wr_n - b_wr), hit ? 32'(n) : 0);
        got = wr_n - b_wr;
        for (int i = 0; i < n && i < got; i++) begin
          ea = rega + 8'(i);
          chk("rnd_w_strobe", 32'(wr_log[b_wr + i]), 32'({ea, dd[8*i +: 8]}));
        end
        if (hit) ptr_m = rega + 8'(n);
      end else begin
        do_read(rega, n, rd, acks);
        tick(2);
        chk("rnd_r_acks", 32'(acks), 3);
        chk("rnd_r_stb", 32'(stb_n - b_stb), 32'(n));
        for (int i = 0; i < n; i++) begin
          ea = rega + 8'(i);
          chk("rnd_r_byte", 32'(rd[8*i +: 8]), 32'(mem[ea]));
        end
        ptr_m = rega + 8'(n - 1);
      end
      chk("rnd_ptr", 32'(bus.rd_addr_o), 32'(ptr_m));
    end

    // Synchronous reset clears the pointer
    do_write(8'hA0, 8'h70, 1, 24'h000055, acks);
    chk("pre_srst_ptr", 32'(bus.rd_addr_o), 32'h71);
    srst_i = 1'b1; tick(1); srst_i = 1'b0;
    chk("srst_ptr", 32'(bus.rd_addr_o), 0);

    // Asynchronous reset while the target is driving SDA low
    mem[8'h60] = 8'h00;
    begin
      logic a;
      m_start(); m_wbyte(8'hA0, a); m_wbyte(8'h60, a);
      m_start(); m_wbyte(8'hA1, a);
    end
    got = 0;
    for (int i = 0; i < 100 && !bus.sda_t; i++) tick(1);
    chk("arst_pre_drive", 32'(bus.sda_t), 1);
    mon_en = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("arst_sda_t", 32'(bus.sda_t), 0);
    chk("arst_busy", 32'(bus.busy_o), 0);
    tick(3);
    rst_ni = 1'b1;
    tick(2);
    chk("arst_ptr", 32'(bus.rd_addr_o), 0);
    m_stop();
    tick(2);
    mon_en = 1'b1;

    chk("sda_change_while_scl_high", 32'(hi_chg), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) responder for the on-board bus.
- Decodes its 7-bit device address, an 8-bit register pointer and data bytes.
- Exposes a simple register write-strobe / read-data interface to the host logic.
- Register-access protocol matches the team's I2C controller: S DADDR+W ac ADDR ac {DATA ac}* P for writes, and S DADDR+W ac ADDR ac Sr DADDR+R ac {data mack}* P for reads.
- Oversamples SCL/SDA on the system clock. No clock stretching.

Parameters:
- DADDR, 7'h50, device address the block responds to.
- SYNC, 2, synchronizer flop stages on scl_i/sda_i (>=2).

Ports:
- clk_i  in  1  system clock; must be >= 16x SCL rate.
- rst_ni  in  1  asynchronous active-low reset.
- srst_i  in  1  synchronous reset, same effect as rst_ni.
- scl_i  in  1  SCL pad input.
- scl_o  out  1  tied 0.
- scl_t  out  1  tied 0; SCL is never driven.
- sda_i  in  1  SDA pad input.
- sda_o  out  1  tied 0.
- sda_t  out  1  1 = pull SDA low, 0 = release.
- wr_val_o  out  1  one-cycle write strobe.
- wr_addr_o  out  8  write register address.
- wr_data_o  out  8  write data.
- rd_addr_o  out  8  current register pointer.
- rd_data_i  in  8  read data for rd_addr_o; sampled combinationally.
- rd_stb_o  out  1  one-cycle pulse when rd_data_i is loaded into the shifter.
- busy_o  out  1  high while addressed (ACKed DADDR) until STOP.

Behaviour:
- Reset (async or srst_i):
  - state = IDLE, ptr = 0, shifter = 0, bit counter = 0.
  - sda_t = 0, wr_val_o = 0, rd_stb_o = 0, wr_addr_o = 0, wr_data_o = 0, busy_o = 0.
  - Synchronizer and previous-sample flops reset to 1 (idle bus).
- Synchronizer and bus events:
  - scl_i and sda_i each pass through SYNC flops, then one history flop.
  - Rise/fall are detected on the synchronized values.
  - START: SDA fall while SCL high. STOP: SDA rise while SCL high.
  - START and STOP take priority over every bit-level action in the same cycle.
- Bit timing:
  - Data is sampled on the synchronized SCL rising edge.
  - sda_t is updated only on the synchronized SCL falling edge, except when released by START/STOP.
- States:
  - IDLE: waits for START.
  - DADR: shifts 8 bits in, MSB first. At the 8th rise, compares [7:1] to DADDR.
    - Match: go to DACK.
    - Mismatch: go to IGNORE.
  - DACK: drive sda_t = 1 from the following SCL fall to the next fall; busy_o = 1.
    - R/W = 0: go to REGA.
    - R/W = 1: go to RDAT. At the fall ending the ACK, load rd_data_i into the shifter, pulse rd_stb_o, and drive its MSB.
  - REGA: shift 8 bits. At the 8th rise, ptr <= byte. Then ACK (RACK), then WDAT.
  - WDAT: shift 8 bits.
    - At the 8th rise: wr_val_o = 1 for one cycle, wr_addr_o = ptr, wr_data_o = byte, ptr <= ptr + 1 (mod 256, 0xFF wraps to 0x00).
    - Then ACK (WACK), then WDAT again.
  - RDAT: on each SCL fall, sda_t = ~shifter[7], then shift left. After 8 bits, release SDA and go to MACK.
  - MACK: sample SDA at the SCL rise.
    - 0 (ACK): ptr <= ptr + 1. At the next fall, load rd_data_i (new ptr), pulse rd_stb_o, drive MSB, go to RDAT.
    - 1 (NACK): go to IGNORE.
  - IGNORE: sda_t = 0; waits for START/STOP.
- START in any state (repeated start): release SDA, bit counter = 0, go to DADR. ptr is kept.
- STOP in any state: release SDA, busy_o = 0, go to IDLE. ptr is kept.
- A START or STOP inside a WDAT byte aborts that byte: no wr_val_o.
- General call (address 0) is not acknowledged.
- SDA is released by the block only on SCL falls, never while SCL is high, except at START/STOP.

Test Plan:
- Write: S 0xA0 ac 0x12 ac 0x5A ac P -> three ACKs (SDA low at the 9th rises); one wr_val_o with wr_addr_o = 0x12, wr_data_o = 0x5A; rd_addr_o = 0x13 afterwards.
- Burst write with wrap: register 0xFF, data 0x01 0x02 -> two strobes, addresses 0xFF then 0x00; final ptr = 0x01.
- Read: S 0xA0 ac 0x40 ac Sr 0xA1 ac, rd_data_i = 0xC3 at 0x40 and 0x3C at 0x41, master ACK then NACK, P -> bytes 0xC3 and 0x3C appear on the bus; rd_stb_o pulses twice; SDA released after the NACK.
- Address mismatch: S 0xA2 ... P -> sda_t stays 0 for the whole transfer; no wr_val_o; busy_o stays 0.
- Abort: STOP after 4 bits of a data byte -> no wr_val_o, state IDLE; a following write transaction works normally.
- Reset mid-read (rst_ni low while sda_t = 1) -> sda_t = 0 immediately (asynchronous); ptr = 0 after release.
